// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
//   Shared constants for the 5-stage LoongArch pipeline: reset PC, inter-stage
//   bus widths and the field offsets of the buses that IF produces/consumes.
//   Imported by if_stage today and by the id/exe/mem/wb stages later.
// -----------------------------------------------------------------------------
package if_stage_pkg;

    // Address of the first instruction fetched after reset.
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    // Inter-stage bus widths.
    localparam int unsigned BR_BUS_WD       = 33;
    localparam int unsigned FS_TO_DS_BUS_WD = 64;
    localparam int unsigned DS_TO_ES_BUS_WD = 150;
    localparam int unsigned ES_TO_MS_BUS_WD = 71;
    localparam int unsigned MS_TO_WS_BUS_WD = 70;

    // br_bus = {br_taken, br_target[31:0]}
    localparam int unsigned BR_TAKEN_BIT   = 32;
    localparam int unsigned BR_TARGET_LSB  = 0;

    // fs_to_ds_bus = {fs_pc[31:0], fs_inst[31:0]}
    localparam int unsigned FS_PC_LSB   = 32;
    localparam int unsigned FS_INST_LSB = 0;

    // Every instruction is one 32-bit word.
    localparam logic [31:0] INST_BYTES = 32'd4;

    // Sequential successor of a PC; wraps modulo 2^32 with no special case.
    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// -----------------------------------------------------------------------------
// if_inst_buf
//   One-entry instruction capture/bypass buffer for the fetch stage. The
//   instruction SRAM only presents read data for one cycle, so when IF holds
//   an instruction that ID cannot take, the data is parked here and replayed
//   for the rest of the stall.
//
// Ports
//   i_clk        clock, all state on posedge
//   i_reset      synchronous active-high reset, empties the buffer
//   i_capture    latch i_rdata into the buffer this edge
//   i_clear      empty the buffer this edge (wins over i_capture)
//   i_rdata      instruction SRAM read data
//   o_buf_valid  buffer holds a parked instruction
//   o_inst       parked instruction when valid, otherwise i_rdata
// -----------------------------------------------------------------------------
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_capture,
    input  logic        i_clear,
    input  logic [31:0] i_rdata,
    output logic        o_buf_valid,
    output logic [31:0] o_inst
);

    logic        r_buf_valid;
    logic [31:0] r_inst_buf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf_valid <= 1'b0;
            r_inst_buf  <= '0;
        end else if (i_clear) begin
            r_buf_valid <= 1'b0;
        end else if (i_capture) begin
            r_buf_valid <= 1'b1;
            r_inst_buf  <= i_rdata;
        end
    end

    assign o_buf_valid = r_buf_valid;
    assign o_inst      = r_buf_valid ? r_inst_buf : i_rdata;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the 5-stage LoongArch pipeline. Owns the PC,
//   drives the synchronous (1-cycle latency) instruction SRAM and hands
//   {pc, inst} to ID over a valid/allowin handshake. Branch redirects from ID
//   cancel the sequential instruction currently in IF and fetch the target in
//   the same cycle.
//
// Ports
//   clk              clock, all state on posedge
//   reset            synchronous active-high reset
//   ds_allowin       ID can accept an instruction this cycle
//   br_bus           {br_taken, br_target[31:0]} from ID; br_taken is a pulse
//   fs_to_ds_valid   fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus     {fs_pc, fs_inst} to ID
//   inst_sram_en     SRAM read request
//   inst_sram_we     SRAM write enable, always 0
//   inst_sram_addr   SRAM fetch address (nextpc)
//   inst_sram_wdata  SRAM write data, always 0
//   inst_sram_rdata  SRAM data for the address requested the previous cycle
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = if_stage_pkg::RESET_PC,
    parameter int unsigned BR_BUS_WD       = if_stage_pkg::BR_BUS_WD,
    parameter int unsigned FS_TO_DS_BUS_WD = if_stage_pkg::FS_TO_DS_BUS_WD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic                       inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    // Architectural IF state.
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;

    // Pre-IF / handshake signals.
    logic        w_to_fs_valid;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_nextpc;
    logic        w_fs_ready_go;
    logic        w_fs_allowin;

    // Buffer control and selected instruction.
    logic        w_buf_capture;
    logic        w_buf_clear;
    logic        w_buf_valid;
    logic [31:0] w_fs_inst;

    assign w_br_taken    = br_bus[BR_TAKEN_BIT];
    assign w_br_target   = br_bus[BR_TARGET_LSB +: 32];

    assign w_to_fs_valid = ~reset;
    assign w_seq_pc      = seq_pc_of(r_fs_pc);
    assign w_nextpc      = w_br_taken ? w_br_target : w_seq_pc;

    // The SRAM always answers in one cycle, so IF never has to wait on it.
    assign w_fs_ready_go = 1'b1;

    // A taken branch frees IF even when ID stalls: the instruction in IF is
    // the wrong-path successor and is dropped, so the target can be fetched.
    assign w_fs_allowin  = ~r_fs_valid | (ds_allowin & w_fs_ready_go) | w_br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            // One word before RESET_PC so seq_pc lands on RESET_PC.
            r_fs_pc    <= RESET_PC - INST_BYTES;
        end else if (w_fs_allowin) begin
            r_fs_valid <= w_to_fs_valid;
            r_fs_pc    <= w_nextpc;
        end
    end

    // Park SRAM data on the first stalled cycle only; later stalled cycles
    // see no fresh read data because no request is issued while stalled.
    assign w_buf_capture = r_fs_valid & ~ds_allowin & ~w_buf_valid & ~w_br_taken;
    assign w_buf_clear   = (r_fs_valid & ds_allowin) | w_br_taken;

    if_inst_buf u_inst_buf (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_capture   (w_buf_capture),
        .i_clear     (w_buf_clear),
        .i_rdata     (inst_sram_rdata),
        .o_buf_valid (w_buf_valid),
        .o_inst      (w_fs_inst)
    );

    // Reset gating keeps the output quiet in the reset cycle itself, before
    // the synchronous clear of r_fs_valid has taken effect.
    assign fs_to_ds_valid  = r_fs_valid & w_fs_ready_go & ~w_br_taken & ~reset;
    assign fs_to_ds_bus    = {r_fs_pc, w_fs_inst};

    assign inst_sram_en    = w_to_fs_valid & w_fs_allowin;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = '0;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC        (32'h1c00_0000),
        .BR_BUS_WD       (33),
        .FS_TO_DS_BUS_WD (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    // SRAM model: inst = ~addr, one cycle after the request. With no request
    // the data bus carries junk, so only the IF buffer can preserve a stalled
    // instruction.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ 32'hffff_ffff;
        else              inst_sram_rdata <= $urandom();
    end

    // ID must only ever send word-aligned branch targets.
    always @(negedge clk) begin
        if (!reset && br_bus[32])
            assert (br_bus[1:0] == 2'b00) else $error("br_target not word aligned: %h", br_bus[31:0]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ds;
        logic        br;
        logic [31:0] tgt;
        logic        ev;     // expected fs_to_ds_valid
        logic        een;    // expected inst_sram_en
        logic [31:0] eaddr;  // expected inst_sram_addr (when een)
        logic [31:0] epc;    // expected fs_pc (when ev)
        logic [31:0] einst;  // expected fs_inst (when ev)
    } vec_t;

    vec_t vecs[21];

    // Random-phase reference: program-order stream of accepted PCs, in-order
    // fetch address stream, and IF occupancy derived from last cycle's events.
    logic [31:0] m_next_pc;
    logic [31:0] m_next_fetch;
    bit          m_prev_issue;
    bit          m_prev_hold;

    initial begin
        // rst ds br tgt | ev een eaddr | epc einst
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h1c00_0000, 32'h0,          32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_0004, 32'h1c00_0000, 32'he3ff_ffff};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_0008, 32'h1c00_0004, 32'he3ff_fffb};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         32'h1c00_0008, 32'he3ff_fff7};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         32'h1c00_0008, 32'he3ff_fff7};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         32'h1c00_0008, 32'he3ff_fff7};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_000c, 32'h1c00_0008, 32'he3ff_fff7};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_0010, 32'h1c00_000c, 32'he3ff_fff3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h1c00_0100,  1'b0, 1'b1, 32'h1c00_0100, 32'h0,          32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_0104, 32'h1c00_0100, 32'he3ff_feff};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         32'h1c00_0104, 32'he3ff_fefb};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h1c00_0200,  1'b0, 1'b1, 32'h1c00_0200, 32'h0,          32'h0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_0204, 32'h1c00_0200, 32'he3ff_fdff};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'hffff_fffc,  1'b0, 1'b1, 32'hffff_fffc, 32'h0,          32'h0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000, 32'hffff_fffc, 32'h0000_0003};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'hffff_ffff};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         32'h0000_0004, 32'hffff_fffb};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         32'h0000_0004, 32'hffff_fffb};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,         32'h0,          32'h0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h1c00_0000, 32'h0,          32'h0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1c00_0004, 32'h1c00_0000, 32'he3ff_ffff};

        reset      = 1'b1;
        ds_allowin = 1'b1;
        br_bus     = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, checked in the last reset cycle.
        @(negedge clk);
        chk("rst_valid", fs_to_ds_valid, 1'b0);
        chk("rst_en",    inst_sram_en,   1'b0);
        chk("sram_we",   inst_sram_we,   1'b0);
        chk("sram_wdata", inst_sram_wdata, 32'h0);
        @(posedge clk);
        #1;

        // Directed table: startup, stall with buffer, branch, branch during
        // buffered stall, wrap past 0xffff_fffc, reset during buffered stall.
        for (int i = 0; i < 21; i++) begin
            reset      = vecs[i].rst;
            ds_allowin = vecs[i].ds;
            br_bus     = {vecs[i].br, vecs[i].tgt};
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), fs_to_ds_valid, vecs[i].ev);
            chk($sformatf("v%0d_en", i),    inst_sram_en,   vecs[i].een);
            if (vecs[i].een) chk($sformatf("v%0d_addr", i), inst_sram_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_pc", i),   fs_to_ds_bus[63:32], vecs[i].epc);
                chk($sformatf("v%0d_inst", i), fs_to_ds_bus[31:0],  vecs[i].einst);
            end
            @(posedge clk);
            #1;
        end

        // Hand-written: a redirect raised while reset is held is dropped and
        // fetch restarts at the reset PC.
        reset      = 1'b1;
        ds_allowin = 1'b1;
        br_bus     = {1'b1, 32'h1c00_0800};
        @(negedge clk);
        chk("rstbr_en",    inst_sram_en,   1'b0);
        chk("rstbr_valid", fs_to_ds_valid, 1'b0);
        @(posedge clk);
        #1;
        br_bus = '0;
        reset  = 1'b0;
        @(negedge clk);
        chk("rstbr_restart_en",   inst_sram_en,   1'b1);
        chk("rstbr_restart_addr", inst_sram_addr, 32'h1c00_0000);
        chk("rstbr_restart_valid", fs_to_ds_valid, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstbr_first_pc", fs_to_ds_bus[63:32], 32'h1c00_0000);
        @(posedge clk);
        #1;

        // Randomized phase against the stream/occupancy reference.
        reset  = 1'b1;
        br_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        m_next_pc    = 32'h1c00_0000;
        m_next_fetch = 32'h1c00_0000;
        m_prev_issue = 1'b0;
        m_prev_hold  = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_ds, r_br, exp_valid, exp_en;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 199) == 0);
            r_ds  = ($urandom_range(0, 9) < 7);
            r_br  = !r_rst && ($urandom_range(0, 9) == 0);
            r_tgt = $urandom() & 32'hffff_fffc;
            if ($urandom_range(0, 3) == 0) r_tgt = 32'hffff_fff0 + (32'($urandom_range(0, 3)) << 2);
            reset      = r_rst;
            ds_allowin = r_ds;
            br_bus     = {r_br, r_br ? r_tgt : 32'($urandom() & 32'hffff_fffc)};
            @(negedge clk);
            if (r_rst) begin
                chk("rnd_rst_valid", fs_to_ds_valid, 1'b0);
                chk("rnd_rst_en",    inst_sram_en,   1'b0);
                m_next_pc    = 32'h1c00_0000;
                m_next_fetch = 32'h1c00_0000;
                m_prev_issue = 1'b0;
                m_prev_hold  = 1'b0;
            end else begin
                // IF holds an instruction if one was fetched last cycle or
                // a stalled one stayed put; a branch hides it.
                exp_valid = !r_br && (m_prev_issue || m_prev_hold);
                exp_en    = r_br || r_ds || !(m_prev_issue || m_prev_hold);
                chk("rnd_valid", fs_to_ds_valid, exp_valid);
                chk("rnd_en",    inst_sram_en,   exp_en);
                if (r_br) begin
                    chk("rnd_br_addr", inst_sram_addr, r_tgt);
                end else if (exp_en) begin
                    chk("rnd_addr", inst_sram_addr, m_next_fetch);
                end
                if (exp_valid) begin
                    chk("rnd_pc",   fs_to_ds_bus[63:32], m_next_pc);
                    chk("rnd_inst", fs_to_ds_bus[31:0],  m_next_pc ^ 32'hffff_ffff);
                end
                if (r_br) begin
                    m_next_pc    = r_tgt;
                    m_next_fetch = r_tgt + 32'd4;
                end else begin
                    if (exp_valid && r_ds) m_next_pc    = m_next_pc + 32'd4;
                    if (exp_en)            m_next_fetch = m_next_fetch + 32'd4;
                end
                m_prev_issue = exp_en;
                m_prev_hold  = exp_valid && !r_ds && !r_br;
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
